// File: rtl/hilo_muldiv_seq.sv
// HI/LO owner for MULT/MULTU/DIV/DIVU: shift-add multiply and restoring divide, one bit per cycle.
// HILO_FAST_MULT_EN (optional) retires multiplies in the start cycle through a full-width multiplier.
// States: IDLE accept start / MTHI / MTLO | RUN one iteration per cycle | FIX sign-correct and commit
module hilo_muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_ni,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] rs_i,
    input  logic [WIDTH-1:0] rt_i,
    input  logic             mthi_i,
    input  logic             mtlo_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             neg_q, neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic             div0_q, div0_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             op_signed;
    logic             op_div;
    logic             rs_neg;
    logic             rt_neg;
    logic [WIDTH-1:0] rs_mag;
    logic [WIDTH-1:0] rt_mag;

    assign op_signed = ~op_i[0];
    assign op_div    = op_i[1];
    assign rs_neg    = op_signed & rs_i[WIDTH-1];
    assign rt_neg    = op_signed & rt_i[WIDTH-1];
    // The most negative value negates to itself, which reads correctly as an unsigned magnitude.
    assign rs_mag    = rs_neg ? -rs_i : rs_i;
    assign rt_mag    = rt_neg ? -rt_i : rt_i;

    logic [WIDTH-1:0] mul_addend;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_sub;

    // Multiply: r_q is the upper partial product, b_q holds the multiplier and collects low bits.
    assign mul_addend = b_q[0] ? a_q : '0;
    assign mul_sum    = {1'b0, r_q} + {1'b0, mul_addend};

    // Divide: r_q is the partial remainder, b_q shifts the dividend out and the quotient in.
    assign div_shift  = {r_q, b_q[WIDTH-1]};
    assign div_ge     = div_shift[WIDTH] | (div_shift[WIDTH-1:0] >= a_q);
    assign div_sub    = div_shift[WIDTH-1:0] - a_q;

    logic [2*WIDTH-1:0] prod_mag;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign prod_mag = {r_q, b_q};
    assign prod_fix = neg_q ? -prod_mag : prod_mag;
    assign quo_fix  = neg_q ? -b_q : b_q;
    assign rem_fix  = rem_neg_q ? -r_q : r_q;

    logic             launch_fast;
    logic             launch_seq;
    logic [WIDTH-1:0] fast_hi;
    logic [WIDTH-1:0] fast_lo;

`ifdef HILO_FAST_MULT_EN
    logic [2*WIDTH-1:0] fast_mag;
    logic [2*WIDTH-1:0] fast_prod;

    assign fast_mag    = {{WIDTH{1'b0}}, rs_mag} * {{WIDTH{1'b0}}, rt_mag};
    assign fast_prod   = (rs_neg ^ rt_neg) ? -fast_mag : fast_mag;
    assign launch_fast = start_i & ~flush_i & ~op_div;
    assign fast_hi     = fast_prod[2*WIDTH-1:WIDTH];
    assign fast_lo     = fast_prod[WIDTH-1:0];
`else
    assign launch_fast = 1'b0;
    assign fast_hi     = '0;
    assign fast_lo     = '0;
`endif

    assign launch_seq = start_i & ~flush_i & ~launch_fast;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        div0_d    = div0_q;
        done_d    = 1'b0;
        a_d       = a_q;
        b_d       = b_q;
        r_d       = r_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            S_IDLE: begin
                if (launch_fast) begin
                    hi_d   = fast_hi;
                    lo_d   = fast_lo;
                    done_d = 1'b1;
                end else if (launch_seq) begin
                    state_d   = S_RUN;
                    cnt_d     = '0;
                    is_div_d  = op_div;
                    neg_d     = rs_neg ^ rt_neg;
                    rem_neg_d = rs_neg;
                    div0_d    = op_div & (rt_i == '0);
                    a_d       = op_div ? rt_mag : rs_mag;
                    b_d       = op_div ? rs_mag : rt_mag;
                    r_d       = '0;
                end else if (!start_i) begin
                    // A start request, even a flushed one, wins arbitration over MT writes.
                    if (mthi_i) hi_d = rs_i;
                    if (mtlo_i) lo_d = rs_i;
                end
            end

            S_RUN: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    if (is_div_q) begin
                        r_d = div_ge ? div_sub : div_shift[WIDTH-1:0];
                        b_d = {b_q[WIDTH-2:0], div_ge};
                    end else begin
                        r_d = mul_sum[WIDTH:1];
                        b_d = {mul_sum[0], b_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) state_d = S_FIX;
                end
            end

            S_FIX: begin
                state_d = S_IDLE;
                if (!flush_i) begin
                    done_d = 1'b1;
                    if (div0_q) begin
                        hi_d = '0;
                        lo_d = '0;
                    end else if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            div0_q    <= 1'b0;
            done_q    <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            r_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            div0_q    <= div0_d;
            done_q    <= done_d;
            a_q       <= a_d;
            b_q       <= b_d;
            r_q       <= r_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy_o = (state_q != S_IDLE);
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_seq.sv
// Bench for hilo_muldiv_seq: directed literal cases plus random traffic against a latency/arithmetic model.
module tb_hilo_muldiv_seq;

    localparam int W = 32;

`ifdef HILO_FAST_MULT_EN
    localparam bit FAST_CFG = 1'b1;
`else
    localparam bit FAST_CFG = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_ni = 1'b0;
    logic          start_i = 1'b0;
    logic [1:0]    op_i = 2'd0;
    logic [W-1:0]  rs_i = '0;
    logic [W-1:0]  rt_i = '0;
    logic          mthi_i = 1'b0;
    logic          mtlo_i = 1'b0;
    logic          flush_i = 1'b0;
    logic          busy_o;
    logic          done_o;
    logic [W-1:0]  hi_o;
    logic [W-1:0]  lo_o;

    always #5 clk = ~clk;

    hilo_muldiv_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset_ni (reset_ni),
        .start_i  (start_i),
        .op_i     (op_i),
        .rs_i     (rs_i),
        .rt_i     (rt_i),
        .mthi_i   (mthi_i),
        .mtlo_i   (mtlo_i),
        .flush_i  (flush_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .hi_o     (hi_o),
        .lo_o     (lo_o)
    );

    int n_cmp = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the ISA definition, using 64-bit integers.
    function automatic void ref_calc(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                                     output logic [31:0] h, output logic [31:0] l);
        longint a, b;
        logic [63:0] p;
        if (op[0]) begin
            a = longint'({32'b0, rs});
            b = longint'({32'b0, rt});
        end else begin
            a = longint'($signed(rs));
            b = longint'($signed(rt));
        end
        if (!op[1]) begin
            p = a * b;
            h = p[63:32];
            l = p[31:0];
        end else if (rt == 32'd0) begin
            h = 32'd0;
            l = 32'd0;
        end else begin
            p = a / b;
            l = p[31:0];
            p = a % b;
            h = p[31:0];
        end
    endfunction

    function automatic bit is_fast(input logic [1:0] op);
        return FAST_CFG && !op[1];
    endfunction

    logic         m_busy, m_done;
    int           m_left;
    logic [31:0]  m_hi, m_lo, m_rhi, m_rlo;

    task automatic model_reset();
        m_busy = 1'b0;
        m_done = 1'b0;
        m_left = 0;
        m_hi   = '0;
        m_lo   = '0;
    endtask

    initial model_reset();

    // Model: result appears WIDTH+1 edges after the start edge unless flushed.
    always @(posedge clk) begin
        if (reset_ni) begin
            m_done = 1'b0;
            if (!m_busy) begin
                if (start_i && !flush_i) begin
                    ref_calc(op_i, rs_i, rt_i, m_rhi, m_rlo);
                    if (is_fast(op_i)) begin
                        m_hi   = m_rhi;
                        m_lo   = m_rlo;
                        m_done = 1'b1;
                    end else begin
                        m_busy = 1'b1;
                        m_left = W + 1;
                    end
                end else if (!start_i) begin
                    if (mthi_i) m_hi = rs_i;
                    if (mtlo_i) m_lo = rs_i;
                end
            end else if (flush_i) begin
                m_busy = 1'b0;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_hi   = m_rhi;
                    m_lo   = m_rlo;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && reset_ni) begin
            chk("busy_o", {31'b0, busy_o}, {31'b0, m_busy});
            chk("done_o", {31'b0, done_o}, {31'b0, m_done});
            chk("hi_o", hi_o, m_hi);
            chk("lo_o", lo_o, m_lo);
        end
    end

    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] rs,
                          input logic [31:0] rt, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int lat;
        @(negedge clk);
        start_i = 1'b1;
        op_i    = op;
        rs_i    = rs;
        rt_i    = rt;
        @(negedge clk);
        start_i = 1'b0;
        lat = 0;
        while (!done_o && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        chk({name, " latency"}, 32'(lat), is_fast(op) ? 32'd0 : 32'd33);
        chk({name, " hi"}, hi_o, exp_hi);
        chk({name, " lo"}, lo_o, exp_lo);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0: v = 32'd0;
            1: v = 32'h8000_0000;
            2: v = 32'hFFFF_FFFF;
            3: v = 32'($urandom_range(0, 15));
            4: v = 32'd0 - 32'($urandom_range(1, 15));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        int ndone;

        repeat (2) @(negedge clk);
        chk("reset busy", {31'b0, busy_o}, 32'd0);
        chk("reset done", {31'b0, done_o}, 32'd0);
        chk("reset hi", hi_o, 32'd0);
        chk("reset lo", lo_o, 32'd0);
        reset_ni = 1'b1;
        chk_en   = 1'b1;

        run_op("MULT", 2'd0, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("MULTU", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("DIVU", 2'd3, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E);
        run_op("DIV neg", 2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("DIV min", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_op("DIV zero", 2'd2, 32'd5, 32'd0, 32'h0000_0000, 32'h0000_0000);
`ifdef HILO_FAST_MULT_EN
        run_op("FAST MULT", 2'd0, 32'd3, 32'd4, 32'h0000_0000, 32'h0000_000C);
`endif

        // MTHI then a flushed DIVU: HI must survive and no done pulse may appear.
        @(negedge clk);
        mthi_i = 1'b1;
        rs_i   = 32'h0000_1234;
        @(negedge clk);
        mthi_i = 1'b0;
        chk("mthi hi", hi_o, 32'h0000_1234);
        chk("mthi busy", {31'b0, busy_o}, 32'd0);
        start_i = 1'b1;
        op_i    = 2'd3;
        rs_i    = 32'd100;
        rt_i    = 32'd7;
        @(negedge clk);
        start_i = 1'b0;
        repeat (9) @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        chk("flush busy", {31'b0, busy_o}, 32'd0);
        chk("flush hi", hi_o, 32'h0000_1234);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_o) ndone++;
        end
        chk("flush no done", 32'(ndone), 32'd0);

        // MTHI while busy is ignored.
        start_i = 1'b1;
        op_i    = 2'd3;
        rs_i    = 32'd100;
        rt_i    = 32'd7;
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        mthi_i = 1'b1;
        rs_i   = 32'h0000_DEAD;
        @(negedge clk);
        mthi_i = 1'b0;
        chk("busy mthi hi", hi_o, 32'h0000_1234);
        chk("busy mthi busy", {31'b0, busy_o}, 32'd1);
        repeat (40) @(negedge clk);
        chk("post DIVU hi", hi_o, 32'h0000_0002);
        chk("post DIVU lo", lo_o, 32'h0000_000E);

        // Asynchronous reset in the middle of RUN.
        start_i = 1'b1;
        op_i    = 2'd2;
        rs_i    = 32'd1000;
        rt_i    = 32'd3;
        @(negedge clk);
        start_i = 1'b0;
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2;
        reset_ni = 1'b0;
        model_reset();
        #1;
        chk("midrun reset busy", {31'b0, busy_o}, 32'd0);
        chk("midrun reset done", {31'b0, done_o}, 32'd0);
        chk("midrun reset hi", hi_o, 32'd0);
        chk("midrun reset lo", lo_o, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_ni = 1'b1;

        repeat (3000) begin
            @(negedge clk);
            start_i = ($urandom_range(0, 7) == 0);
            op_i    = 2'($urandom_range(0, 3));
            rs_i    = pick();
            rt_i    = pick();
            mthi_i  = ($urandom_range(0, 5) == 0);
            mtlo_i  = ($urandom_range(0, 5) == 0);
            flush_i = ($urandom_range(0, 99) == 0);
            if (start_i && flush_i) begin
                mthi_i = 1'b0;
                mtlo_i = 1'b0;
            end
        end
        @(negedge clk);
        start_i = 1'b0;
        mthi_i  = 1'b0;
        mtlo_i  = 1'b0;
        flush_i = 1'b0;
        repeat (40) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
